icap_rr_arbiter: RTL
====================

# icap_rr_arbiter

Round-robin arbiter that shares the single ICAP primitive between NUM_REQ configuration masters, such as the SEM controller, the PR controller and a debug/readback engine. It implements the cap REQ/GNT/REL handshake per requester and multiplexes the write side of the ICAP. A per-requester lock lets a master keep the ICAP after an error. A release timeout revokes the grant from a master that ignores REL. It sits between the requester ICAP ports and the ICAPE3 instance; the read path (avail/o/prdone/prerror) is fanned out outside this block.

## Interface
- NUM_REQ, 4 — number of requesters, 2..8
- TIMEOUT_CYCLES, 1024 — max cycles in RELEASE before forced revoke; 0 disables the timeout
- icap_clk  in  1  ICAP clock; all logic is on this edge
- icap_resetn  in  1  asynchronous, active-low reset
- arb_req  in  NUM_REQ  cap REQ per requester
- arb_gnt  out  NUM_REQ  cap GNT per requester, one-hot or zero, registered
- arb_rel  out  NUM_REQ  cap REL per requester, registered, only ever set on the owner
- arb_lock  in  NUM_REQ  owner holds the ICAP, preemption and timeout suppressed
- req_icap_csib  in  NUM_REQ  per-requester csib
- req_icap_rdwrb  in  NUM_REQ  per-requester rdwrb
- req_icap_i  in  32*NUM_REQ  per-requester data, requester k at [32k+31:32k]
- icap_csib  out  1  to ICAP
- icap_rdwrb  out  1  to ICAP
- icap_i  out  32  to ICAP
- owner_valid  out  1  a grant is active
- owner_id  out  clog2(NUM_REQ)  index of the current owner; 0 when no owner
- timeout_pulse  out  1  one-cycle pulse on each forced revoke

## Operation
- **Reset values:** arb_gnt=0, arb_rel=0, owner_valid=0, owner_id=0, timeout_pulse=0, rr_ptr=0, state IDLE. The mux outputs idle at icap_csib=1, icap_rdwrb=1, icap_i=0.
- **States:** IDLE, GRANT, RELEASE, GAP.
- **Pick rule:** choose the first k with arb_req[k]=1, scanning from rr_ptr upward and wrapping modulo NUM_REQ.
- **IDLE and GAP:** both run the pick.
  - If any request is present: set gnt[k], owner_id=k, owner_valid=1, rr_ptr=(k+1) mod NUM_REQ, go to GRANT.
  - Otherwise go to (or stay in) IDLE.
- **GRANT:**
  - Owner req=0: clear gnt, go to GAP.
  - Else, if another req is pending and lock[owner]=0: set rel[owner], clear tmo_cnt, go to RELEASE.
  - A lock that is high only defers the release; it never blocks voluntary release.
- **RELEASE:**
  - Owner req=0: clear gnt and rel, go to GAP.
  - Else, if lock[owner]=1: REL stays high and tmo_cnt is frozen.
  - Else tmo_cnt++. When tmo_cnt reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): clear gnt and rel, pulse timeout_pulse, go to GAP.
  - If all other requests vanish: stay in RELEASE with REL high until the owner releases. REL is never withdrawn.
- **Mux:** purely combinational from the registered gnt and owner_id.
  - While owner_valid: icap_csib/rdwrb/i take the owner's inputs.
  - Otherwise the idle values.
- **GAP:** guarantees csib=1 for at least one cycle between owners.
- **Width:** tmo_cnt is clog2(TIMEOUT_CYCLES+1) bits and saturates.
- **Reset mid-transfer:** gnt drops immediately (asynchronous) and icap_csib returns to 1. The ICAP sequence is aborted; recovery is the requesters' job.

## Timing
- **Grant latency:** req rises at edge t (in IDLE) → gnt high after edge t+1.
- **Handover:** owner req observed low at edge t → gnt low after t. The next owner's gnt is high after t+1 (GAP cycle), so there is exactly one idle cycle.
- **REL:** high one cycle after the competing req is first sampled in GRANT.
- **Forced revoke:** gnt falls TIMEOUT_CYCLES cycles after REL rose, with no lock. timeout_pulse is high for that one cycle, aligned with gnt falling.
- **Simultaneous events:** owner drop plus a new req in the same cycle follows the normal handover. Several reqs from IDLE are resolved by rr_ptr only.

## Structure
- **Package icap_arb_pkg:** state encoding (IDLE=0, GRANT=1, RELEASE=2, GAP=3), ICAP_W=32, idle mux constants.
- **Sub-module icap_rr_pick:** combinational round-robin priority encoder. Inputs are req vector and ptr; outputs are found and idx.

## Test plan
- NUM_REQ=4, only req[2] rises at cycle 10 → gnt=4'b0100 at 11, owner_id=2, icap_i follows req_icap_i[95:64].
- Owner 0 held, req[1] and req[3] rise together → rel[0]=1. Owner drops → one cycle with csib=1, then gnt=4'b0010. Next handover goes to 3.
- Owner 1 ignores REL, TIMEOUT_CYCLES=16 → gnt[1] falls 16 cycles after rel[1] rose, timeout_pulse=1 for 1 cycle, next owner granted after the GAP.
- Owner 2 asserts lock during RELEASE for 100 cycles → no revoke, rel[2] stays high. Lock drops → revoke 16 cycles later.
- icap_resetn pulled low while owner 3 is streaming → gnt=0 and icap_csib=1 immediately. After release, rr_ptr=0 and req[3],req[1] pending → owner 1 is granted first.

Source files
------------

// File: rtl/icap_arb_pkg.sv
// icap_arb_pkg: shared definitions for the ICAP round-robin arbiter.
//   - arb_state_e : arbiter FSM encoding (IDLE=0, GRANT=1, RELEASE=2, GAP=3)
//   - ICAP_W      : ICAP data width
//   - IDLE_*      : values driven onto the ICAP when no master owns it
//   - tmo_width() : width of the release-timeout counter for a given limit
package icap_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } arb_state_e;

  localparam int ICAP_W = 32;

  localparam logic              IDLE_CSIB  = 1'b1;
  localparam logic              IDLE_RDWRB = 1'b1;
  localparam logic [ICAP_W-1:0] IDLE_DATA  = '0;

  // A disabled timeout (0 cycles) still gets a 1-bit counter so the
  // declaration stays legal.
  function automatic int tmo_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/icap_rr_pick.sv
// icap_rr_pick: combinational round-robin priority encoder.
//   req   in  NUM_REQ  request vector
//   ptr   in  IW       index to start scanning from (wraps modulo NUM_REQ)
//   found out 1        at least one request is set
//   idx   out IW       first set request at or after ptr; 0 when none
module icap_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  always_comb begin : scan
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/icap_rr_arbiter.sv
// icap_rr_arbiter: shares one ICAP primitive between NUM_REQ configuration
// masters with round-robin fairness and multiplexes the ICAP write side.
//   icap_clk, icap_resetn    clock, asynchronous active-low reset
//   arb_req/arb_gnt/arb_rel  per-requester REQ/GNT/REL handshake
//   arb_lock                 owner keeps the ICAP (defers release/timeout)
//   req_icap_csib/rdwrb/i    per-requester ICAP write-side signals
//   icap_csib/rdwrb/i        muxed ICAP write side
//   owner_valid, owner_id    current owner (id is 0 when none)
//   timeout_pulse            one cycle on each forced revoke
//   arb_state                FSM state (arb_state_e encoding) for observation
//
// Handshake: a master raises REQ and keeps it high for as long as it wants
// the ICAP. GNT (registered, one-hot or zero) tells it that it owns the ICAP
// from the following cycle on. When someone else is waiting the owner sees
// REL; it must finish its sequence and drop REQ, which ends its ownership at
// the next edge. REL is never withdrawn while the owner holds the grant. An
// owner that ignores REL (and holds no lock) loses GNT after TIMEOUT_CYCLES.
module icap_rr_arbiter
  import icap_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic                      icap_clk,
  input  logic                      icap_resetn,
  input  logic [NUM_REQ-1:0]        arb_req,
  output logic [NUM_REQ-1:0]        arb_gnt,
  output logic [NUM_REQ-1:0]        arb_rel,
  input  logic [NUM_REQ-1:0]        arb_lock,
  input  logic [NUM_REQ-1:0]        req_icap_csib,
  input  logic [NUM_REQ-1:0]        req_icap_rdwrb,
  input  logic [ICAP_W*NUM_REQ-1:0] req_icap_i,
  output logic                      icap_csib,
  output logic                      icap_rdwrb,
  output logic [ICAP_W-1:0]         icap_i,
  output logic                      owner_valid,
  output logic [IW-1:0]             owner_id,
  output logic                      timeout_pulse,
  output logic [1:0]                arb_state
);

  localparam int            TW       = tmo_width(TIMEOUT_CYCLES);
  localparam bit            TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rel_q, rel_d;
  logic               owner_valid_q, owner_valid_d;
  logic [IW-1:0]      owner_id_q, owner_id_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic               tmo_pulse_q, tmo_pulse_d;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic               owner_req;
  logic               owner_lock;
  logic               others_req;

  icap_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (arb_req),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_req  = arb_req[owner_id_q];
  assign owner_lock = arb_lock[owner_id_q];
  // gnt_q masks out the owner itself; it is zero outside GRANT/RELEASE.
  assign others_req = |(arb_req & ~gnt_q);

  always_ff @(posedge icap_clk or negedge icap_resetn) begin
    if (!icap_resetn) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      rel_q         <= '0;
      owner_valid_q <= 1'b0;
      owner_id_q    <= '0;
      rr_ptr_q      <= '0;
      tmo_cnt_q     <= '0;
      tmo_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rel_q         <= rel_d;
      owner_valid_q <= owner_valid_d;
      owner_id_q    <= owner_id_d;
      rr_ptr_q      <= rr_ptr_d;
      tmo_cnt_q     <= tmo_cnt_d;
      tmo_pulse_q   <= tmo_pulse_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rel_d         = rel_q;
    owner_valid_d = owner_valid_q;
    owner_id_d    = owner_id_q;
    rr_ptr_d      = rr_ptr_q;
    tmo_cnt_d     = tmo_cnt_q;
    tmo_pulse_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_found) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          owner_id_d      = pick_idx;
          owner_valid_d   = 1'b1;
          rr_ptr_d        = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
          state_d         = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GRANT: begin
        if (!owner_req) begin
          gnt_d         = '0;
          owner_valid_d = 1'b0;
          owner_id_d    = '0;
          state_d       = ST_GAP;
        end else if (others_req && !owner_lock) begin
          rel_d[owner_id_q] = 1'b1;
          tmo_cnt_d         = '0;
          state_d           = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (!owner_req) begin
          gnt_d         = '0;
          rel_d         = '0;
          owner_valid_d = 1'b0;
          owner_id_d    = '0;
          state_d       = ST_GAP;
        end else if (owner_lock) begin
          // Locked owner: REL stays up, the timeout clock is frozen.
          tmo_cnt_d = tmo_cnt_q;
        end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
          gnt_d         = '0;
          rel_d         = '0;
          owner_valid_d = 1'b0;
          owner_id_d    = '0;
          tmo_pulse_d   = 1'b1;
          state_d       = ST_GAP;
        end else if (tmo_cnt_q != '1) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Write-side mux driven only from registered ownership, so the ICAP sees
  // the idle values for the whole GAP cycle between two owners.
  always_comb begin
    icap_csib  = IDLE_CSIB;
    icap_rdwrb = IDLE_RDWRB;
    icap_i     = IDLE_DATA;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_valid_q && (owner_id_q == IW'(k))) begin
        icap_csib  = req_icap_csib[k];
        icap_rdwrb = req_icap_rdwrb[k];
        icap_i     = req_icap_i[k*ICAP_W +: ICAP_W];
      end
    end
  end

  assign arb_gnt       = gnt_q;
  assign arb_rel       = rel_q;
  assign owner_valid   = owner_valid_q;
  assign owner_id      = owner_id_q;
  assign timeout_pulse = tmo_pulse_q;
  assign arb_state     = state_q;

endmodule
